uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
UART transmit serializer. It is the transmit-side counterpart of the RX path.
It runs on the divided TX clock, so one i_clk cycle equals one bit period, and emits standard frames: start, data LSB-first, optional parity, stop.
A one-entry holding register lets upstream logic (register file / ALU result path) queue the next byte while a frame is in flight, which gives back-to-back frames with no idle bit.

Parameters:
DATA_WIDTH, 8, number of data bits per frame.

Ports:
i_clk  input  1  TX bit clock; one cycle per transmitted bit.
i_rst  input  1  synchronous reset, active-high.
i_tx_data  input  DATA_WIDTH  byte to transmit.
i_data_valid  input  1  upstream offers i_tx_data this cycle.
o_ready  output  1  holding register empty; byte accepted on a rising edge where i_data_valid && o_ready.
i_par_en  input  1  1 = append a parity bit.
i_par_typ  input  1  0 = even parity, 1 = odd parity.
o_tx_out  output  1  serial line; idles high.
o_busy  output  1  high while o_tx_out carries a frame bit (start..stop inclusive).

Behaviour:
- Clocking and reset: one clock (i_clk); reset is synchronous and active-high (i_rst).
- Reset values: o_tx_out=1, o_busy=0, o_ready=1. Holding register empty, FSM=IDLE, shifter and bit counter cleared.
- Acceptance:
  - On an edge with i_data_valid && o_ready, the block captures the byte together with i_par_en/i_par_typ into the holding register.
  - Parity is computed at capture: even -> XOR of data bits; odd -> inverted XOR.
  - Later changes to i_par_* never affect an already-accepted byte.
- o_ready = !hold_full, a register-derived output with no combinational path from i_data_valid.
- i_data_valid while o_ready=0 is ignored; the byte is not captured and no error is raised. Upstream must hold its data.
- Output timing: o_tx_out and o_busy are registered. Each frame bit lasts exactly one cycle.
- FSM states and transitions:
  - IDLE: o_tx_out=1, o_busy=0. If hold_full, the next edge loads the shifter from hold, clears hold, drives start bit (0), sets o_busy=1 -> START.
  - START -> DATA: next edge drives data bit 0.
  - DATA: shifts LSB-first for DATA_WIDTH cycles; the counter counts 0..DATA_WIDTH-1. After the last bit -> PARITY if the captured par_en=1, else -> STOP.
  - PARITY: one cycle with the captured parity bit -> STOP.
  - STOP: one cycle with o_tx_out=1. On the edge ending STOP:
    - if hold_full, load it and drive start bit 0 immediately (no idle cycle) -> START;
    - else o_tx_out=1, o_busy=0 -> IDLE.
- Latency: byte accepted at edge k with the FSM in IDLE -> start bit on o_tx_out from edge k+1; data bit i from edge k+2+i; parity (if enabled) from k+2+DATA_WIDTH; stop after that.
- o_ready is low only for cycle k..k+1 in that case.
- Frame length: DATA_WIDTH+2 cycles without parity, DATA_WIDTH+3 with parity.
- Mid-frame acceptance: a byte offered while the frame is in flight and hold is empty is captured; o_ready stays 0 until the edge that ends the current STOP.
- Simultaneous events: hold load into the shifter and a new capture cannot occur on the same edge, because o_ready=0 whenever hold is full.
- Reset mid-frame: on the reset edge, o_tx_out returns to 1, o_busy=0, hold is cleared and the partial frame is abandoned (no stop bit completion).
- Bit counter width: $clog2(DATA_WIDTH)+1. It never wraps within a frame.

Test Plan:
1. Assert i_rst for 2 cycles with i_data_valid=1 -> o_tx_out=1, o_busy=0, o_ready=1 after reset; no byte is captured during reset.
2. Send 0xA5 with par_en=0 -> o_tx_out = 0,1,0,1,0,0,1,0,1,1 over 10 cycles starting the edge after acceptance; o_busy high for exactly those 10 cycles.
3. Send 0xA5 with par_en=1, par_typ=0 -> parity bit 0, 11-cycle frame. Repeat with par_typ=1 -> parity bit 1. Toggle i_par_typ mid-frame -> frame unchanged.
4. Send 0x00, then offer 0xFF during data bit 3 -> 0xFF captured; o_ready=0 until the first frame's STOP ends; the second start bit immediately follows the stop bit; o_busy stays high continuously for 20 cycles.
5. While hold is full, offer 0x3C -> ignored; only 0x00 and 0xFF appear on the line.
6. Assert i_rst during data bit 4 of 0x81 -> o_tx_out=1, o_busy=0, o_ready=1 next cycle. A subsequent 0x55 transmits a clean 10-bit frame.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer clocked at the bit rate: start, LSB-first data, optional parity, stop.
// A one-entry holding register allows the next byte to be queued so frames run back-to-back.
//
// state  | meaning
// S_IDLE | line high, waiting for the holding register to fill
// S_START| start bit (0) on the line
// S_DATA | data bits, LSB first, bit_cnt = index of the bit on the line
// S_PARITY| parity bit captured with the byte
// S_STOP | stop bit (1); reloads from hold without an idle bit if one is queued
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_data_valid,
  output logic                  o_ready,
  input  logic                  i_par_en,
  input  logic                  i_par_typ,
  output logic                  o_tx_out,
  output logic                  o_busy
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t state_q, state_n;

  logic                  hold_full;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_par_en;
  logic                  hold_par_bit;

  logic [DATA_WIDTH-1:0] shift_q, shift_n;
  logic [CW-1:0]         cnt_q, cnt_n;
  logic                  frame_par_en;
  logic                  frame_par_bit;
  logic                  tx_q, tx_n;
  logic                  busy_q, busy_n;
  logic                  load;

  assign o_ready  = ~hold_full;
  assign o_tx_out = tx_q;
  assign o_busy   = busy_q;

  // Parity is frozen at capture so later i_par_* changes cannot alter a queued byte.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hold_full    <= 1'b0;
      hold_data    <= '0;
      hold_par_en  <= 1'b0;
      hold_par_bit <= 1'b0;
    end else if (load) begin
      hold_full <= 1'b0;
    end else if (i_data_valid && !hold_full) begin
      hold_full    <= 1'b1;
      hold_data    <= i_tx_data;
      hold_par_en  <= i_par_en;
      hold_par_bit <= i_par_typ ? ~(^i_tx_data) : (^i_tx_data);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      shift_q       <= '0;
      cnt_q         <= '0;
      tx_q          <= 1'b1;
      busy_q        <= 1'b0;
      frame_par_en  <= 1'b0;
      frame_par_bit <= 1'b0;
    end else begin
      state_q <= state_n;
      shift_q <= shift_n;
      cnt_q   <= cnt_n;
      tx_q    <= tx_n;
      busy_q  <= busy_n;
      if (load) begin
        frame_par_en  <= hold_par_en;
        frame_par_bit <= hold_par_bit;
      end
    end
  end

  always_comb begin
    state_n = state_q;
    shift_n = shift_q;
    cnt_n   = cnt_q;
    tx_n    = tx_q;
    busy_n  = busy_q;
    load    = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (hold_full) begin
          load    = 1'b1;
          shift_n = hold_data;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
          state_n = S_START;
        end
      end
      S_START: begin
        tx_n    = shift_q[0];
        shift_n = shift_q >> 1;
        cnt_n   = '0;
        state_n = S_DATA;
      end
      S_DATA: begin
        if (cnt_q == LAST_BIT) begin
          if (frame_par_en) begin
            tx_n    = frame_par_bit;
            state_n = S_PARITY;
          end else begin
            tx_n    = 1'b1;
            state_n = S_STOP;
          end
        end else begin
          tx_n    = shift_q[0];
          shift_n = shift_q >> 1;
          cnt_n   = cnt_q + CW'(1);
        end
      end
      S_PARITY: begin
        tx_n    = 1'b1;
        state_n = S_STOP;
      end
      S_STOP: begin
        if (hold_full) begin
          load    = 1'b1;
          shift_n = hold_data;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
          state_n = S_START;
        end else begin
          tx_n    = 1'b1;
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end
      end
      default: begin
        tx_n    = 1'b1;
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: expected line bits are queued at byte acceptance
// and popped by a negedge monitor whenever o_busy is high.
module tb_uart_tx_serializer;

  logic       i_clk;
  logic       i_rst;
  logic [7:0] i_tx_data;
  logic       i_data_valid;
  logic       o_ready;
  logic       i_par_en;
  logic       i_par_typ;
  logic       o_tx_out;
  logic       o_busy;

  int n_vec = 0;
  int n_err = 0;
  bit sb[$];
  bit mon_en = 1'b0;
  int run_len = 0;
  int last_run = 0;

  uart_tx_serializer #(.DATA_WIDTH(8)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_tx_data   (i_tx_data),
    .i_data_valid(i_data_valid),
    .o_ready     (o_ready),
    .i_par_en    (i_par_en),
    .i_par_typ   (i_par_typ),
    .o_tx_out    (o_tx_out),
    .o_busy      (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (!mon_en) begin
      run_len = 0;
    end else if (o_busy) begin
      run_len++;
      chk("bit_available", (sb.size() > 0), 1);
      if (sb.size() > 0) chk("tx_bit", o_tx_out, sb.pop_front());
    end else begin
      chk("idle_line", o_tx_out, 1);
      if (run_len > 0) last_run = run_len;
      run_len = 0;
    end
  end

  // Offer a byte until accepted; from_idle also checks the one-cycle start latency.
  task automatic send(input logic [7:0] d, input bit pe, input bit pt, input bit from_idle);
    int  n = 0;
    bit  acc = 1'b0;
    i_tx_data    = d;
    i_par_en     = pe;
    i_par_typ    = pt;
    i_data_valid = 1'b1;
    while (!acc && n < 100) begin
      acc = o_ready;
      @(posedge i_clk); #1;
      n++;
    end
    i_data_valid = 1'b0;
    chk("accept_timeout", acc, 1);
    sb.push_back(1'b0);
    for (int i = 0; i < 8; i++) sb.push_back(d[i]);
    if (pe) sb.push_back(pt ^ (^d));
    sb.push_back(1'b1);
    if (from_idle) begin
      chk("ready_after_accept", o_ready, 0);
      chk("busy_before_start", o_busy, 0);
      @(posedge i_clk); #1;
      chk("start_busy", o_busy, 1);
      chk("start_bit", o_tx_out, 0);
      chk("ready_after_load", o_ready, 1);
    end
  endtask

  task automatic wait_idle(input int exp_len);
    int n = 0;
    while ((sb.size() != 0 || o_busy) && n < 300) begin
      @(posedge i_clk); #1;
      n++;
    end
    @(negedge i_clk); #1;
    chk("frame_timeout", (n < 300), 1);
    chk("busy_run", last_run, exp_len);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    i_rst        = 1'b1;
    i_data_valid = 1'b1;
    i_tx_data    = 8'h5A;
    i_par_en     = 1'b0;
    i_par_typ    = 1'b0;

    // 1: reset with valid asserted
    repeat (2) begin @(posedge i_clk); #1; end
    chk("rst_ready", o_ready, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_tx", o_tx_out, 1);
    i_rst        = 1'b0;
    i_data_valid = 1'b0;
    mon_en       = 1'b1;
    repeat (3) begin @(posedge i_clk); #1; end
    chk("no_capture_busy", o_busy, 0);
    chk("no_capture_ready", o_ready, 1);

    // 2: 0xA5 without parity
    send(8'hA5, 1'b0, 1'b0, 1'b1);
    wait_idle(10);

    // 3: parity even, odd, and i_par_typ toggled mid-frame
    send(8'hA5, 1'b1, 1'b0, 1'b1);
    wait_idle(11);
    send(8'hA5, 1'b1, 1'b1, 1'b1);
    repeat (3) begin @(posedge i_clk); #1; end
    i_par_typ = 1'b0;
    repeat (2) begin @(posedge i_clk); #1; end
    i_par_typ = 1'b1;
    @(posedge i_clk); #1;
    i_par_typ = 1'b0;
    wait_idle(11);

    // 4/5: 0x00 then 0xFF queued during data bit 3; 0x3C offered while hold is full
    send(8'h00, 1'b0, 1'b0, 1'b1);
    repeat (4) begin @(posedge i_clk); #1; end
    send(8'hFF, 1'b0, 1'b0, 1'b0);
    i_tx_data    = 8'h3C;
    i_data_valid = 1'b1;
    repeat (3) begin
      chk("full_ready", o_ready, 0);
      @(posedge i_clk); #1;
    end
    i_data_valid = 1'b0;
    chk("hold_ready_a", o_ready, 0);
    @(posedge i_clk); #1;
    chk("hold_ready_b", o_ready, 0);
    chk("first_stop", o_tx_out, 1);
    @(posedge i_clk); #1;
    chk("release_ready", o_ready, 1);
    chk("b2b_start", o_tx_out, 0);
    chk("b2b_busy", o_busy, 1);
    wait_idle(20);

    // 6: reset during data bit 4 of 0x81, then a clean 0x55
    send(8'h81, 1'b0, 1'b0, 1'b1);
    repeat (5) begin @(posedge i_clk); #1; end
    mon_en = 1'b0;
    i_rst  = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    chk("midrst_tx", o_tx_out, 1);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_ready", o_ready, 1);
    sb.delete();
    mon_en = 1'b1;
    @(posedge i_clk); #1;
    chk("abandon_busy", o_busy, 0);
    chk("abandon_tx", o_tx_out, 1);
    send(8'h55, 1'b0, 1'b0, 1'b1);
    wait_idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
